rr16_grant_sched: RTL and testbench
===================================

# rr16_grant_sched

Round-robin scheduler that shares the 4-to-16 selector among 16 requesters. It arbitrates a 16-bit request vector and holds a registered grant, including a bounded hold time. It drives the selector's A3..A0 address and disable lines directly, so at most one selector output is active per cycle. It sits between the requesting units and the selector and provides fair, starvation-free access.

## Interface
Parameters:
- HOLD_MAX, 4: maximum consecutive cycles one owner keeps the grant while another request is pending; legal range 1..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low; one clock, synchronous reset, active-low.
- en  in  1  scheduler enable; low aborts any grant.
- req  in  16  request vector; bit i = requester i wants the selector.
- grant  out  16  one-hot registered grant; all-zero when nobody owns the selector.
- addr  out  4  owner index, wired to selector A3..A0.
- dis  out  1  selector disable; 1 whenever grant is all-zero.
- busy  out  1  high in the GRANT state.

## Operation
- States:
  - IDLE: no owner.
  - GRANT: owner valid.
  - GAP: one dead cycle after a release; only present with RR16_GAP_EN.
- Round-robin pick:
  - Winner is the first set bit of req scanning upward from ptr, wrapping 15 -> 0.
  - ptr is a 4-bit pointer.
- IDLE:
  - If en=1 and req!=0, the winner is latched and the state becomes GRANT.
  - Otherwise stay in IDLE.
- GRANT, with owner o and hold counter cnt (8-bit, value 1 in the first grant cycle, saturating at 255):
  - If en=0, go to IDLE.
  - If req[o]=0, release.
  - If cnt>=HOLD_MAX and (req & ~(1<<o))!=0, release (forced rotation).
  - Otherwise stay in GRANT and increment cnt.
  - Uncontested owners are never forced off; cnt saturates.
- Release sets ptr=o+1 mod 16 and goes to GAP, or arbitrates immediately (see Configuration).
  - The released owner is excluded from the immediate re-pick only through the ptr advance. It competes normally and wins only if it is the sole requester.
- GAP: the next state follows the same rule as IDLE.
- Outputs:
  - grant = one-hot(o) in GRANT, zero otherwise.
  - addr = o in GRANT; addr holds its last value in IDLE/GAP.
  - dis = ~busy.
- en=0 mid-grant: grant drops on the next edge; ptr is not advanced.

## Timing
- Reset values: state=IDLE, grant=0, addr=0, dis=1, busy=0, ptr=0, cnt=0.
- Latency:
  - req rise in IDLE to grant is one cycle (registered).
  - A req drop is seen at the next edge, so the grant falls one cycle after req falls.
- Handover, contested, HOLD_MAX=H: the owner is visible exactly H cycles.
  - With the gap: 1 idle cycle, then the next owner.
  - Without the gap: the next owner appears on the cycle after the last owner cycle.
- Simultaneous events:
  - Release and new requests in the same cycle: arbitration uses req sampled at that edge.
  - en=0 takes priority over everything.
  - rst=0 takes priority over en.
- Reset mid-grant: all outputs return to reset values at that edge.

## Configuration
- RR16_GAP_EN:
  - Defined: every release passes through GAP, giving one cycle of dis=1 between owners. This is break-before-make for the selector outputs.
  - Undefined: the GAP state is not compiled. Release arbitrates in the same cycle and loads the next owner directly (dis stays 0 if another request exists).

## Structure
- Package rr16_pkg contains:
  - state enum {IDLE, GRANT, GAP}
  - N_REQ=16
  - IDX_W=4
  - CNT_W=8
- Sub-module rr16_pick: combinational rotate, priority-encode, rotate back. Inputs req[15:0] and ptr[3:0]; outputs idx[3:0] and valid.
- Top contains the FSM, counter, pointer and output registers.

## Test plan
- Reset: hold rst=0 for 2 cycles with req=16'hFFFF -> grant=0, dis=1, addr=0, busy=0.
- Single requester: req=16'h0020 from IDLE -> next cycle grant=16'h0020, addr=5, dis=0. Drop req -> one cycle later grant=0.
- Rotation, HOLD_MAX=4, req=16'h8001 held:
  - Owner 0 for 4 cycles, then owner 15 for 4 cycles, then owner 0.
  - With RR16_GAP_EN, one dis=1 cycle between owners; without it, none.
- Wrap and fairness: ptr=14, req=16'h4002 -> owner 14 first, then 1. ptr after release of 1 is 2.
- Uncontested hold: req=16'h0008 held for 300 cycles -> grant never drops; cnt saturates at 255.
- Abort: en=0 during grant of owner 7 -> grant=0 next cycle, ptr unchanged. en=1 with req=16'h0080 -> owner 7 again.

Source files
------------

// File: rtl/rr16_pkg.sv
// Shared types and sizes for the 16-way round-robin selector scheduler.
package rr16_pkg;
  localparam int N_REQ = 16;
  localparam int IDX_W = 4;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
endpackage

// File: rtl/rr16_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping 15 -> 0.
module rr16_pick
  import rr16_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   enc;

  // Rotate so ptr lands on bit 0, then the lowest set bit is the winner.
  assign dbl = {req, req};
  assign rot = dbl[ptr +: N_REQ];

  always_comb begin
    enc = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) enc = IDX_W'(i);
    end
  end

  assign idx   = enc + ptr;
  assign valid = |req;
endmodule

// File: rtl/rr16_grant_sched.sv
// Round-robin grant scheduler driving the 4-to-16 selector address/disable lines.
// Optional one-cycle dead gap between owners when RR16_GAP_EN is defined.
module rr16_grant_sched
  import rr16_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] addr,
  output logic             dis,
  output logic             busy
);
  localparam logic [CNT_W-1:0] HOLD = CNT_W'(HOLD_MAX);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   pick_ptr, pick_idx;
  logic               pick_vld;
  logic [N_REQ-1:0]   others;
  logic               rel;

  // In GRANT the pick is only consumed on release, where ptr becomes owner+1.
  assign pick_ptr = (state_q == GRANT) ? owner_q + IDX_W'(1) : ptr_q;

  rr16_pick u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .idx   (pick_idx),
    .valid (pick_vld)
  );

  assign others = req & ~(N_REQ'(1) << owner_q);
  assign rel    = !req[owner_q] || ((cnt_q >= HOLD) && (|others));

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      GRANT: begin
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (rel) begin
          ptr_d = owner_q + IDX_W'(1);
`ifdef RR16_GAP_EN
          state_d = GAP;
          cnt_d   = '0;
`else
          if (pick_vld) begin
            owner_d = pick_idx;
            cnt_d   = CNT_W'(1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
`endif
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        if (en && pick_vld) begin
          state_d = GRANT;
          owner_d = pick_idx;
          cnt_d   = CNT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
    endcase
    grant_d = (state_d == GRANT) ? (N_REQ'(1) << owner_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
    end
  end

  assign grant = grant_q;
  assign addr  = owner_q;
  assign busy  = (state_q == GRANT);
  assign dis   = ~busy;
endmodule

// File: tb/tb_rr16_grant_sched.sv
// Directed bench for rr16_grant_sched: per-cycle compare against an abstract model plus literal pins.
module tb_rr16_grant_sched;
  localparam int HOLD = 4;

  logic        clk, rst, en;
  logic [15:0] req;
  logic [15:0] grant;
  logic [3:0]  addr;
  logic        dis, busy;

  int checks = 0;
  int errors = 0;
  bit run = 0;

  rr16_grant_sched #(.HOLD_MAX(HOLD)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .grant(grant), .addr(addr), .dis(dis), .busy(busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Model: st 0=no owner, 1=owner, 2=dead gap cycle.
  typedef struct {
    int st;
    int owner;
    int cnt;
    int ptr;
  } mdl_t;

  mdl_t m = '{0, 0, 0, 0};

  function automatic int mpick(logic [15:0] r, int p);
    for (int k = 0; k < 16; k++) begin
      if (r[(p + k) % 16]) return (p + k) % 16;
    end
    return -1;
  endfunction

  function automatic mdl_t mstep(mdl_t c, logic r_n, logic e, logic [15:0] r);
    mdl_t n = c;
    int w;
    bit contested;
    if (!r_n) return '{0, 0, 0, 0};
    if (c.st == 1) begin
      contested = 0;
      for (int k = 0; k < 16; k++) if (r[k] && k != c.owner) contested = 1;
      if (!e) begin
        n.st = 0;
      end else if (!r[c.owner] || (c.cnt >= HOLD && contested)) begin
        n.ptr = (c.owner + 1) % 16;
`ifdef RR16_GAP_EN
        n.st = 2;
`else
        w = mpick(r, n.ptr);
        if (w >= 0) begin
          n.owner = w;
          n.cnt = 1;
        end else begin
          n.st = 0;
        end
`endif
      end else if (c.cnt < 255) begin
        n.cnt = c.cnt + 1;
      end
    end else begin
      w = mpick(r, c.ptr);
      if (e && w >= 0) begin
        n.st = 1;
        n.owner = w;
        n.cnt = 1;
      end else begin
        n.st = 0;
      end
    end
    return n;
  endfunction

  always @(posedge clk) m <= mstep(m, rst, en, req);

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("model_grant", 32'(grant), (m.st == 1) ? 32'(16'(1) << m.owner) : 32'h0);
      chk("model_addr", 32'(addr), 32'(m.owner));
      chk("model_busy", 32'(busy), (m.st == 1) ? 32'd1 : 32'd0);
      chk("model_dis", 32'(dis), (m.st == 1) ? 32'd0 : 32'd1);
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 0; en = 1; req = 16'hFFFF;
    cyc(2);
    run = 1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_dis", 32'(dis), 32'd1);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Contested rotation between 0 and 15.
    rst = 1; req = 16'h8001;
    cyc(1);
    chk("rot_first", 32'(grant), 32'h0001);
    cyc(3);
    chk("rot_hold4", 32'(grant), 32'h0001);
    cyc(1);
`ifdef RR16_GAP_EN
    chk("rot_gap", 32'(dis), 32'd1);
    cyc(1);
`endif
    chk("rot_next", 32'(grant), 32'h8000);
    cyc(4);
`ifdef RR16_GAP_EN
    cyc(1);
`endif
    chk("rot_back", 32'(grant), 32'h0001);
    req = 16'h0000;
    cyc(3);

    // Single requester.
    req = 16'h0020;
    cyc(1);
    chk("single_grant", 32'(grant), 32'h0020);
    chk("single_addr", 32'(addr), 32'd5);
    chk("single_dis", 32'(dis), 32'd0);
    req = 16'h0000;
    cyc(1);
    chk("single_drop", 32'(grant), 32'h0);
    cyc(2);

    // Wrap: park ptr at 14 via owner 13.
    req = 16'h2000;
    cyc(1);
    req = 16'h0000;
    cyc(3);
    req = 16'h4002;
    cyc(1);
    chk("wrap_first", 32'(grant), 32'h4000);
    cyc(4);
`ifdef RR16_GAP_EN
    cyc(1);
`endif
    chk("wrap_second", 32'(grant), 32'h0002);
    req = 16'h0000;
    cyc(3);
    req = 16'h0003;
    cyc(1);
    chk("wrap_ptr2", 32'(grant), 32'h0001);
    req = 16'h0000;
    cyc(3);

    // Uncontested hold with saturating counter.
    req = 16'h0008;
    cyc(1);
    chk("hold_start", 32'(grant), 32'h0008);
    cyc(300);
    chk("hold_300", 32'(grant), 32'h0008);
    req = 16'h0018;
    cyc(1);
`ifdef RR16_GAP_EN
    chk("hold_contest", 32'(grant), 32'h0);
    cyc(1);
`endif
    chk("hold_next", 32'(grant), 32'h0010);
    req = 16'h0000;
    cyc(3);

    // Abort with en=0; ptr must stay put.
    req = 16'h0180;
    cyc(1);
    chk("abort_own7", 32'(grant), 32'h0080);
    en = 0;
    cyc(1);
    chk("abort_drop", 32'(grant), 32'h0);
    chk("abort_busy", 32'(busy), 32'd0);
    en = 1;
    cyc(1);
    chk("abort_again", 32'(grant), 32'h0080);
    chk("abort_addr", 32'(addr), 32'd7);

    // Reset mid-grant.
    req = 16'hFFFF; rst = 0;
    cyc(1);
    chk("midrst_grant", 32'(grant), 32'h0);
    chk("midrst_addr", 32'(addr), 32'd0);
    rst = 1; req = 16'h0000;
    cyc(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
